// File: rtl/bitwise_pipe.sv
// bitwise_pipe: registered WIDTH-bit bitwise logic unit with per-bit mask,
// valid/ready on both sides, a 2-entry output FIFO and a wrapping debug counter.
module bitwise_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_tail;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] w_res;
  logic             w_push;
  logic             w_pop;

  // Unmasked operation result, selected by op
  always_comb begin
    w_f = '0;
    case (op)
      3'b000:  w_f = ~a;
      3'b001:  w_f = a & b;
      3'b010:  w_f = a | b;
      3'b011:  w_f = a ^ b;
      3'b100:  w_f = ~(a & b);
      3'b101:  w_f = ~(a | b);
      3'b110:  w_f = ~(a ^ b);
      default: w_f = a;
    endcase
  end

  // Masked-off bits pass operand A through unchanged
  assign w_res = (mask & w_f) | (~mask & a);

  // Handshake flags decode only registered state (reset_n gates in_ready low during reset)
  assign in_ready  = reset_n && (r_state != S_TWO);
  assign out_valid = (r_state != S_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign y        = r_y;
  assign done_cnt = r_cnt;

  // Occupancy FSM with head (y) and tail (skid) registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_EMPTY;
      r_y     <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            r_y     <= w_res;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            r_y <= w_res;
          end else if (w_push) begin
            r_tail  <= w_res;
            r_state <= S_TWO;
          end else if (w_pop) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            r_y     <= r_tail;
            r_state <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  // Completed output handshakes, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bitwise_pipe.sv
// tb_bitwise_pipe: directed scoreboard bench for bitwise_pipe (WIDTH=4, CNT_W=2).
module tb_bitwise_pipe;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    op;
  logic [W-1:0]  mask;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic [CW-1:0] done_cnt;

  int unsigned   n_pass  = 0;
  int unsigned   n_total = 0;
  logic [W-1:0]  sb[$];
  logic [W-1:0]  cur_exp;
  logic [CW-1:0] exp_cnt;

  bitwise_pipe #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: record handshakes seen before the edge, then advance to edge+1
  task automatic tick();
    logic popped;
    logic [W-1:0] e;
    popped = 1'b0;
    if (in_valid && in_ready) sb.push_back(cur_exp);
    if (out_valid && out_ready) begin
      popped = 1'b1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("y_pop", 32'(y), 32'(e));
      end
      exp_cnt = exp_cnt + CW'(1);
    end
    @(posedge clk);
    #1;
    if (popped) chk("done_cnt", 32'(done_cnt), 32'(exp_cnt));
  endtask

  task automatic set_beat(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [2:0] iop, input logic [W-1:0] imask,
                          input logic [W-1:0] iexp);
    a = ia; b = ib; op = iop; mask = imask; cur_exp = iexp;
    in_valid = 1'b1;
  endtask

  // Offer a beat until accepted (bounded), then withdraw in_valid
  task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [2:0] iop, input logic [W-1:0] imask,
                      input logic [W-1:0] iexp);
    logic acc;
    acc = 1'b0;
    set_beat(ia, ib, iop, imask, iexp);
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = in_ready;
      tick();
    end
    if (!acc) chk("send_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    chk("drain_empty", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    logic [1:0] sweep_lo [8];
    sweep_lo = '{2'b11, 2'b00, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b00};
    exp_cnt  = '0;
    cur_exp  = '0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; op = '0; mask = '0;

    // Reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_y", 32'(y), 32'(0));
    chk("rst_cnt", 32'(done_cnt), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;

    // Single NOT beat, one-cycle latency
    out_ready = 1'b1;
    send(4'b1010, 4'b0000, 3'b000, 4'hF, 4'b0101);
    chk("lat_out_valid", 32'(out_valid), 32'(1));
    chk("lat_y", 32'(y), 32'(4'b0101));
    tick();
    chk("one_cnt", 32'(done_cnt), 32'(1));
    chk("one_empty", 32'(out_valid), 32'(0));

    // Op sweep under mask 0011
    for (int i = 0; i < 8; i++)
      send(4'b1100, 4'b1010, 3'(i), 4'b0011, {2'b11, sweep_lo[i]});
    drain();

    // Back-pressure: two beats absorbed, third held
    out_ready = 1'b0;
    send(4'h1, 4'hF, 3'b011, 4'hF, 4'hE);
    chk("bp_ready_one", 32'(in_ready), 32'(1));
    send(4'h2, 4'hF, 3'b011, 4'hF, 4'hD);
    chk("bp_full", 32'(in_ready), 32'(0));
    set_beat(4'h3, 4'hF, 3'b011, 4'hF, 4'hC);
    tick();
    tick();
    chk("bp_held_ready", 32'(in_ready), 32'(0));
    chk("bp_held_valid", 32'(out_valid), 32'(1));
    chk("bp_head_y", 32'(y), 32'(4'hE));
    out_ready = 1'b1;
    tick();
    chk("bp_ready_back", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    drain();

    // Streaming NOT with simultaneous accept/pop
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("stream_ready", 32'(in_ready), 32'(1));
      send(4'(i), 4'h0, 3'b000, 4'hF, ~4'(i));
      chk("stream_valid", 32'(out_valid), 32'(1));
    end
    drain();

    // Async reset while full
    out_ready = 1'b0;
    send(4'h6, 4'h0, 3'b111, 4'hF, 4'h6);
    send(4'h7, 4'h0, 3'b111, 4'hF, 4'h7);
    chk("ar_full", 32'(in_ready), 32'(0));
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'(0));
    chk("ar_y", 32'(y), 32'(0));
    chk("ar_cnt", 32'(done_cnt), 32'(0));
    chk("ar_in_ready", 32'(in_ready), 32'(0));
    sb.delete();
    exp_cnt = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // First beat after reset is the first output; counter wraps 1,2,3,0,1
    out_ready = 1'b1;
    send(4'h5, 4'h0, 3'b000, 4'hF, 4'hA);
    chk("post_rst_y", 32'(y), 32'(4'hA));
    tick();
    chk("wrap_1", 32'(done_cnt), 32'(1));
    send(4'h9, 4'h3, 3'b001, 4'hF, 4'h1);
    tick();
    chk("wrap_2", 32'(done_cnt), 32'(2));
    send(4'h9, 4'h3, 3'b010, 4'hF, 4'hB);
    tick();
    chk("wrap_3", 32'(done_cnt), 32'(3));
    send(4'h9, 4'h3, 3'b101, 4'hF, 4'h4);
    tick();
    chk("wrap_0", 32'(done_cnt), 32'(0));
    send(4'h9, 4'h3, 3'b110, 4'hF, 4'h5);
    tick();
    chk("wrap_1b", 32'(done_cnt), 32'(1));
    chk("final_sb", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
